// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target exposing a 16-bit register pointer and byte read/write strobes.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL and SDA.
module i2c_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h29
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        SCL_in,
  input  logic        SDA_in,
  output logic        SDA_out,
  output logic        SDA_t,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [7:0]  reg_rdata,
  output logic        busy,
  output logic        error_out
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REGH, REGH_ACK, REGL, REGL_ACK,
    WRITE, WRITE_ACK, READ, READ_ACK
  } state_t;

  state_t      state;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_f, sda_f, scl_prev, sda_prev;
  logic [2:0]  bit_cnt;
  logic        rose;
  logic [6:0]  shreg;
  logic [7:0]  tx, ptr_hi;
  logic        rw;
  logic [1:0]  re_pipe;
  logic [1:0]  ack_phase;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], SCL_in};
      sda_sync <= {sda_sync[0], SDA_in};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_f <= (scl_hist[1] & scl_hist[0]) | (scl_hist[1] & scl_sync[1]) | (scl_hist[0] & scl_sync[1]);
      sda_f <= (sda_hist[1] & sda_hist[0]) | (sda_hist[1] & sda_sync[1]) | (sda_hist[0] & sda_sync[1]);
    end
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_f;
      sda_prev <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det, last_bit, in_byte;
  logic [7:0] rx_byte;
  assign scl_rise  = scl_f & ~scl_prev;
  assign scl_fall  = ~scl_f & scl_prev;
  assign start_det = scl_f & scl_prev & sda_prev & ~sda_f;
  assign stop_det  = scl_f & scl_prev & ~sda_prev & sda_f;
  assign last_bit  = scl_rise && (bit_cnt == 3'd7);
  assign rx_byte   = {shreg, sda_f};
  assign in_byte   = (state == ADDR) || (state == REGH) || (state == REGL) ||
                     (state == WRITE) || (state == READ);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      SDA_out   <= 1'b0;
      SDA_t     <= 1'b1;
      reg_addr  <= 16'h0000;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      error_out <= 1'b0;
      bit_cnt   <= 3'd0;
      rose      <= 1'b0;
      shreg     <= 7'd0;
      tx        <= 8'h00;
      ptr_hi    <= 8'h00;
      rw        <= 1'b0;
      re_pipe   <= 2'b00;
      ack_phase <= 2'd0;
    end else begin
      SDA_out   <= 1'b0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      error_out <= 1'b0;
      re_pipe   <= {re_pipe[0], reg_re};
      if (re_pipe[1]) tx <= reg_rdata;
      if (start_det || stop_det) begin
        error_out <= (bit_cnt != 3'd0);
        bit_cnt   <= 3'd0;
        rose      <= 1'b0;
        SDA_t     <= 1'b1;
        ack_phase <= 2'd0;
        if (stop_det) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          state <= ADDR;
        end
      end else begin
        // A bit only counts once its SCL fall follows a sampled rise, so the
        // falls after START and the rise before a repeated START/STOP do not.
        if (in_byte) begin
          if (scl_rise) begin
            shreg <= {shreg[5:0], sda_f};
            rose  <= 1'b1;
          end else if (scl_fall && rose) begin
            bit_cnt <= bit_cnt + 3'd1;
            rose    <= 1'b0;
          end
        end
        if (last_bit) begin
          bit_cnt <= 3'd0;
          rose    <= 1'b0;
        end
        case (state)
          IDLE: ;
          ADDR: if (last_bit) begin
            if (shreg == SLAVE_ADDR) begin
              rw    <= sda_f;
              busy  <= 1'b1;
              state <= ADDR_ACK;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          REGH: if (last_bit) begin
            ptr_hi <= rx_byte;
            state  <= REGH_ACK;
          end
          REGL: if (last_bit) begin
            reg_addr <= {ptr_hi, rx_byte};
            state    <= REGL_ACK;
          end
          WRITE: if (last_bit) begin
            reg_we    <= 1'b1;
            reg_wdata <= rx_byte;
            state     <= WRITE_ACK;
          end
          ADDR_ACK, REGH_ACK, REGL_ACK, WRITE_ACK: begin
            if (scl_rise && !SDA_t && rw && (state == ADDR_ACK)) reg_re <= 1'b1;
            if (scl_fall) begin
              if (SDA_t) begin
                SDA_t <= 1'b0;
              end else begin
                SDA_t <= 1'b1;
                case (state)
                  ADDR_ACK: if (rw) begin
                    SDA_t <= tx[7];
                    tx    <= {tx[6:0], 1'b0};
                    state <= READ;
                  end else begin
                    state <= REGH;
                  end
                  REGH_ACK: state <= REGL;
                  REGL_ACK: state <= WRITE;
                  default: begin
                    reg_addr <= reg_addr + 16'd1;
                    state    <= WRITE;
                  end
                endcase
              end
            end
          end
          READ: begin
            if (last_bit) begin
              ack_phase <= 2'd0;
              state     <= READ_ACK;
            end else if (scl_fall) begin
              SDA_t <= tx[7];
              tx    <= {tx[6:0], 1'b0};
            end
          end
          READ_ACK: begin
            case (ack_phase)
              2'd0: begin
                if (scl_fall) SDA_t <= 1'b1;
                if (scl_rise) begin
                  if (!sda_f) begin
                    reg_addr  <= reg_addr + 16'd1;
                    reg_re    <= 1'b1;
                    ack_phase <= 2'd1;
                  end else begin
                    ack_phase <= 2'd2;
                  end
                end
              end
              2'd1: if (scl_fall) begin
                SDA_t     <= tx[7];
                tx        <= {tx[6:0], 1'b0};
                ack_phase <= 2'd0;
                state     <= READ;
              end
              default: ;
            endcase
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - Directed bus-master bench for i2c_target.
module tb_i2c_target;
  localparam int Q = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [7:0]  reg_rdata = 8'h00;
  logic        SCL_in, SDA_in, SDA_out, SDA_t, reg_we, reg_re, busy, error_out;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;
  int sdat_low = 0;
  logic [23:0] we_log[$];
  logic [15:0] re_log[$];

  assign SCL_in = m_scl;
  assign SDA_in = m_sda & (SDA_t | SDA_out);

  always #5 clock = ~clock;

  i2c_target #(.SLAVE_ADDR(7'h29)) dut (
    .clock(clock), .reset(reset), .SCL_in(SCL_in), .SDA_in(SDA_in),
    .SDA_out(SDA_out), .SDA_t(SDA_t), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy),
    .error_out(error_out)
  );

  always @(negedge clock) begin
    if (reg_we) we_log.push_back({reg_addr, reg_wdata});
    if (reg_re) re_log.push_back(reg_addr);
    if (error_out) err_pulses++;
    if (!SDA_t) sdat_low++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; tick(2);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(3);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_scl = 1'b0; tick(3);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q / 2);
    b = SDA_in; tick(Q / 2);
    m_scl = 1'b0; tick(3);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(3);
    checks++; if (SDA_t !== 1'b1) begin errors++; $display("FAIL reset_sda_t: got %b want 1", SDA_t); end
    checks++; if (SDA_out !== 1'b0) begin errors++; $display("FAIL reset_sda_out: got %b want 0", SDA_out); end
    checks++; if (reg_addr !== 16'h0000) begin errors++; $display("FAIL reset_reg_addr: got %h want 0000", reg_addr); end
    checks++; if (reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_reg_wdata: got %h want 00", reg_wdata); end
    checks++; if ({reg_we, reg_re, busy, error_out} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b want 0000", {reg_we, reg_re, busy, error_out}); end
    reset = 1'b0; tick(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_write();
    logic [7:0] b [4];
    logic ack;
    logic [23:0] got;
    int we0, e0;
    b = '{8'h52, 8'h01, 8'h0F, 8'hA5};
    we0 = we_log.size(); e0 = err_pulses;
    bus_start();
    for (int i = 0; i < 4; i++) begin
      write_byte(b[i], ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL write_ack%0d: got %b want 0", i, ack); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b want 1", busy); end
    bus_stop();
    checks++; if (we_log.size() - we0 != 1) begin errors++; $display("FAIL write_we_count: got %0d want 1", we_log.size() - we0); end
    got = (we_log.size() > we0) ? we_log[we0] : 24'hxxxxxx;
    checks++; if (got !== {16'h010F, 8'hA5}) begin errors++; $display("FAIL write_we_addr_data: got %h want 010fa5", got); end
    checks++; if (reg_addr !== 16'h0110) begin errors++; $display("FAIL write_addr_inc: got %h want 0110", reg_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop: got %b want 0", busy); end
    checks++; if (err_pulses != e0) begin errors++; $display("FAIL write_no_error: got %0d want 0", err_pulses - e0); end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] d;
    logic [15:0] ra;
    int re0, e0, nacks;
    re0 = re_log.size(); e0 = err_pulses; nacks = 0;
    reg_rdata = 8'hEA;
    bus_start();
    write_byte(8'h52, ack); nacks += int'(ack);
    write_byte(8'h01, ack); nacks += int'(ack);
    write_byte(8'h0F, ack); nacks += int'(ack);
    checks++; if (nacks != 0) begin errors++; $display("FAIL read_ptr_acks: got %0d nacks want 0", nacks); end
    bus_start();
    write_byte(8'h53, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL read_addr_ack: got %b want 0", ack); end
    read_byte(1'b1, d);
    checks++; if (d !== 8'hEA) begin errors++; $display("FAIL read_data: got %h want ea", d); end
    checks++; if (re_log.size() - re0 != 1) begin errors++; $display("FAIL read_re_count: got %0d want 1", re_log.size() - re0); end
    ra = (re_log.size() > re0) ? re_log[re0] : 16'hxxxx;
    checks++; if (ra !== 16'h010F) begin errors++; $display("FAIL read_re_addr: got %h want 010f", ra); end
    checks++; if (reg_addr !== 16'h010F) begin errors++; $display("FAIL read_no_inc: got %h want 010f", reg_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy: got %b want 1", busy); end
    bus_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_stop: got %b want 0", busy); end
    checks++; if (err_pulses != e0) begin errors++; $display("FAIL read_no_error: got %0d want 0", err_pulses - e0); end
  endtask

  task automatic test_nomatch();
    logic ack;
    int we0, re0, s0;
    we0 = we_log.size(); re0 = re_log.size(); s0 = sdat_low;
    bus_start();
    write_byte(8'h60, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL nomatch_ack: got %b want 1", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nomatch_busy: got %b want 0", busy); end
    bus_stop();
    checks++; if (sdat_low != s0) begin errors++; $display("FAIL nomatch_sda_t: got %0d low cycles want 0", sdat_low - s0); end
    checks++; if ((we_log.size() != we0) || (re_log.size() != re0)) begin errors++; $display("FAIL nomatch_strobes: got we=%0d re=%0d want 0 0", we_log.size() - we0, re_log.size() - re0); end
  endtask

  task automatic test_wrap();
    logic [7:0] b [5];
    logic ack;
    logic [23:0] g0, g1;
    int we0, nacks;
    b = '{8'h52, 8'hFF, 8'hFF, 8'h11, 8'h22};
    we0 = we_log.size(); nacks = 0;
    bus_start();
    for (int i = 0; i < 5; i++) begin
      write_byte(b[i], ack);
      nacks += int'(ack);
    end
    bus_stop();
    checks++; if (nacks != 0) begin errors++; $display("FAIL wrap_acks: got %0d nacks want 0", nacks); end
    checks++; if (we_log.size() - we0 != 2) begin errors++; $display("FAIL wrap_we_count: got %0d want 2", we_log.size() - we0); end
    g0 = (we_log.size() > we0) ? we_log[we0] : 24'hxxxxxx;
    g1 = (we_log.size() > we0 + 1) ? we_log[we0 + 1] : 24'hxxxxxx;
    checks++; if (g0 !== {16'hFFFF, 8'h11}) begin errors++; $display("FAIL wrap_first: got %h want ffff11", g0); end
    checks++; if (g1 !== {16'h0000, 8'h22}) begin errors++; $display("FAIL wrap_second: got %h want 000022", g1); end
    checks++; if (reg_addr !== 16'h0001) begin errors++; $display("FAIL wrap_final_addr: got %h want 0001", reg_addr); end
  endtask

  task automatic test_stop_error();
    logic ack;
    int e0;
    e0 = err_pulses;
    bus_start();
    write_byte(8'h52, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    bus_stop();
    checks++; if (err_pulses - e0 != 1) begin errors++; $display("FAIL stop_error_pulse: got %0d want 1", err_pulses - e0); end
    checks++; if (SDA_t !== 1'b1) begin errors++; $display("FAIL stop_error_sda_t: got %b want 1", SDA_t); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_error_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    reg_rdata = 8'h3C;
    bus_start();
    write_byte(8'h53, ack);
    tick(4);
    checks++; if ({SDA_t, SDA_in} !== 2'b00) begin errors++; $display("FAIL mid_read_driving: got SDA_t/SDA=%b want 00", {SDA_t, SDA_in}); end
    reset = 1'b1;
    #1;
    checks++; if (SDA_t !== 1'b1) begin errors++; $display("FAIL mid_reset_sda_t: got %b want 1", SDA_t); end
    checks++; if ({SDA_out, reg_addr, reg_wdata} !== 25'd0) begin errors++; $display("FAIL mid_reset_regs: got %h want 0", {SDA_out, reg_addr, reg_wdata}); end
    checks++; if ({reg_we, reg_re, busy, error_out} !== 4'b0000) begin errors++; $display("FAIL mid_reset_strobes: got %b want 0000", {reg_we, reg_re, busy, error_out}); end
    m_scl = 1'b1; m_sda = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(6);
    checks++; if ({SDA_t, busy} !== 2'b10) begin errors++; $display("FAIL mid_reset_after: got SDA_t/busy=%b want 10", {SDA_t, busy}); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nomatch();
    test_wrap();
    test_stop_error();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
